minute_stage: RTL and testbench
===============================

MINUTE_STAGE -- requirements
Module: minute_stage

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, number of consecutive clk cycles a synchronized button must be stable high before it counts as a press (range 2..255).
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick_m, input, 1, synchronous one-cycle enable from the seconds stage, one pulse per elapsed minute.
REQ-005 SHALL have port set_mode, input, 1, synchronous level; high = time-set mode.
REQ-006 SHALL have port btn_min, input, 1, asynchronous raw push button (minute adjust), active-high.
REQ-007 SHALL have port btn_hr, input, 1, asynchronous raw push button (hour adjust), active-high.
REQ-008 SHALL have port min_10, output, 4, BCD tens of minutes (0..5), registered.
REQ-009 SHALL have port min1, output, 4, BCD units of minutes (0..9), registered.
REQ-010 SHALL have port w_h, output, 1, registered hour-advance pulse consumed as the hour counter's rising-edge clock.

Function
REQ-011 SHALL synchronize each button through two flip-flops before any use.
REQ-012 SHALL debounce each synchronized button with an independent counter; counter clears whenever the synchronized level is low, increments while high, saturates at DB_CYCLES.
REQ-013 SHALL generate exactly one press event per button in the single cycle its debounce counter reaches DB_CYCLES; holding the button produces no further events until it has been low for at least one cycle.
REQ-014 SHALL, in run mode (set_mode=0), advance minutes by one on each cycle with tick_m=1; button events are discarded.
REQ-015 SHALL advance as BCD: min1 9->0 with min_10+1; at 59 wrap to 00.
REQ-016 SHALL, in run mode only, assert w_h for exactly one clk cycle, the cycle after the clock edge on which the count wraps 59->00.
REQ-017 SHALL, in set mode (set_mode=1), ignore tick_m entirely.
REQ-018 SHALL, in set mode, advance minutes by one per btn_min press event with the same BCD wrap, and SHALL NOT assert w_h on a 59->00 wrap caused by btn_min.
REQ-019 SHALL, in set mode, assert w_h for exactly one clk cycle, the cycle after each btn_hr press event; minutes unchanged.
REQ-020 SHALL, when btn_min and btn_hr events occur in the same set-mode cycle, perform both actions in that cycle.
REQ-021 SHALL evaluate mode from set_mode as sampled on the same edge as tick_m/events; a tick_m coinciding with the cycle set_mode first samples high is ignored.
REQ-022 SHALL, on any update cycle, treat an illegal stored value (min1>9 or min_10>5) as 00 before incrementing, yielding 01.
REQ-023 SHALL hold w_h low in every cycle not named in REQ-016/REQ-019; w_h SHALL be a direct flip-flop output, glitch-free.
REQ-024 SHALL guarantee w_h is never high in two consecutive cycles; a 59->00 run wrap and btn_hr cannot coincide because modes are exclusive.

Reset
REQ-025 SHALL, while rst=0, force min_10=0, min1=0, w_h=0, synchronizer flops=0, debounce counters=0, regardless of clk.
REQ-026 SHALL, after rst deasserts, take no action before the first rising clk edge; a press in progress at reset SHALL be re-qualified from zero count.
REQ-027 SHALL abort an in-flight w_h pulse immediately when rst asserts (w_h drops asynchronously).

Verification
REQ-028 Reset then 60 tick_m pulses in run mode -> minutes 00..59 then 00; w_h high exactly one cycle, one cycle after the 60th tick edge.
REQ-029 Run mode, minutes 09, one tick_m -> min_10=1, min1=0, w_h stays 0.
REQ-030 set_mode=1, minutes 58, three clean btn_min presses (each held 20 cycles, DB_CYCLES=16) -> 59, 00, 01; w_h never asserted; tick_m pulses during set mode have no effect.
REQ-031 set_mode=1, btn_hr bouncing 0/1 every 3 cycles for 30 cycles then stable high 40 cycles -> exactly one w_h pulse, 17-19 cycles after stable high starts (2 sync + 16 debounce).
REQ-032 Force min1=12 via backdoor, run mode, one tick_m -> 01; rst pulsed low mid-w_h -> w_h low within the reset assertion, outputs 00.

Source files
------------

// File: rtl/minute_stage.sv
// Minutes stage of a BCD clock: two-digit minutes counter with run/set modes and an hour-advance pulse.
// Latency: minutes and w_h update on the clk edge that samples tick_m or a press event; a press event
// fires 2 sync + DB_CYCLES edges after the raw button goes high. No backpressure: every enable acts at once.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - asynchronous active-low reset
//   tick_m   - one-cycle enable, one per elapsed minute (run mode only)
//   set_mode - level, 1 = time-set mode (buttons active, tick_m ignored)
//   btn_min  - raw asynchronous minute-adjust button, active-high
//   btn_hr   - raw asynchronous hour-adjust button, active-high
//   min_10   - BCD tens of minutes (0..5), registered
//   min1     - BCD units of minutes (0..9), registered
//   w_h      - registered one-cycle hour-advance pulse
module minute_stage #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_m,
  input  logic       set_mode,
  input  logic       btn_min,
  input  logic       btn_hr,
  output logic [3:0] min_10,
  output logic [3:0] min1,
  output logic       w_h
);

  localparam logic [7:0] DB_MAX  = 8'(DB_CYCLES);
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  // Button lanes: index 0 = minute button, index 1 = hour button.
  logic [1:0] btn_raw;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [7:0] db_cnt [2];
  logic [1:0] press;

  assign btn_raw = {btn_hr, btn_min};

  // Two-flop synchronizer per button; nothing downstream sees the raw pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: count consecutive synchronized-high cycles, clear on any low,
  // saturate so a held button stays parked at DB_MAX without re-firing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!sync_b[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != DB_MAX) begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // The press event is the one cycle whose edge moves the counter onto DB_MAX.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = sync_b[i] && (db_cnt[i] == DB_LAST);
    end
  end

  // Minutes datapath.
  logic       legal;
  logic [3:0] base_10;
  logic [3:0] base_1;
  logic [3:0] nxt_10;
  logic [3:0] nxt_1;
  logic       at_59;
  logic       upd;
  logic       wh_nxt;

  always_comb begin
    legal   = (min1 <= 4'd9) && (min_10 <= 4'd5);
    // A corrupted count restarts from 00 so the next increment lands on 01.
    base_10 = legal ? min_10 : 4'd0;
    base_1  = legal ? min1   : 4'd0;
    at_59   = (base_10 == 4'd5) && (base_1 == 4'd9);

    nxt_10 = base_10;
    nxt_1  = base_1 + 4'd1;
    if (base_1 == 4'd9) begin
      nxt_1 = 4'd0;
      if (base_10 == 4'd5) begin
        nxt_10 = 4'd0;
      end else begin
        nxt_10 = base_10 + 4'd1;
      end
    end

    // Modes are exclusive, so a run wrap and an hour press can never collide
    // and w_h cannot be high on two consecutive cycles.
    if (set_mode) begin
      upd    = press[0];
      wh_nxt = press[1];
    end else begin
      upd    = tick_m;
      wh_nxt = tick_m && at_59;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_10 <= 4'd0;
      min1   <= 4'd0;
      w_h    <= 1'b0;
    end else begin
      if (upd) begin
        min_10 <= nxt_10;
        min1   <= nxt_1;
      end
      w_h <= wh_nxt;
    end
  end

endmodule

// File: tb/tb_minute_stage.sv
module tb_minute_stage;

  localparam int DB = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       tick_m   = 1'b0;
  logic       set_mode = 1'b0;
  logic       btn_min  = 1'b0;
  logic       btn_hr   = 1'b0;
  logic [3:0] min_10;
  logic [3:0] min1;
  logic       w_h;

  minute_stage #(.DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_m   (tick_m),
    .set_mode (set_mode),
    .btn_min  (btn_min),
    .btn_hr   (btn_hr),
    .min_10   (min_10),
    .min1     (min1),
    .w_h      (w_h)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: minutes as a plain integer 0..59 (raw digits kept so a
  // corrupted value can be represented), buttons as run lengths of raw samples.
  int m10_e = 0;
  int m1_e  = 0;
  bit wh_e  = 1'b0;
  int rlm1 = 0, rlm2 = 0, rlh1 = 0, rlh2 = 0;
  int bd_seq = 0, bd_seen = 0, bd_m10 = 0, bd_m1 = 0;
  int mv;
  bit mevm, mevh, mlegal, mupd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m10_e   = 0;
      m1_e    = 0;
      wh_e    = 1'b0;
      rlm1    = 0;
      rlm2    = 0;
      rlh1    = 0;
      rlh2    = 0;
      bd_seen = bd_seq;
    end else begin
      if (bd_seen != bd_seq) begin
        m10_e   = bd_m10;
        m1_e    = bd_m1;
        bd_seen = bd_seq;
      end
      // A press fires when the raw sample two edges back completed a high run
      // of exactly DB samples (two sync stages, then DB qualifying cycles).
      mevm = (rlm2 == DB);
      mevh = (rlh2 == DB);
      rlm2 = rlm1;
      rlm1 = btn_min ? ((rlm1 < 1000) ? rlm1 + 1 : rlm1) : 0;
      rlh2 = rlh1;
      rlh1 = btn_hr ? ((rlh1 < 1000) ? rlh1 + 1 : rlh1) : 0;

      mlegal = (m1_e <= 9) && (m10_e <= 5);
      mv     = mlegal ? (m10_e * 10 + m1_e) : 0;
      mupd   = set_mode ? mevm : tick_m;
      wh_e   = set_mode ? mevh : (tick_m && mv == 59);
      if (mupd) begin
        mv    = (mv + 1) % 60;
        m10_e = mv / 10;
        m1_e  = mv % 10;
      end
    end
  end

  int wh_seen = 0;

  function automatic int val();
    return int'(min_10) * 10 + int'(min1);
  endfunction

  // One clock: wait for the edge, sample 1 time unit later, compare to model.
  task automatic step();
    @(posedge clk);
    #1;
    check("min_10", int'(min_10), m10_e);
    check("min1", int'(min1), m1_e);
    check("w_h", int'(w_h), int'(wh_e));
    if (w_h) wh_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_min_10", int'(min_10), 0);
    check("rst_min1", int'(min1), 0);
    check("rst_w_h", int'(w_h), 0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic do_tick();
    tick_m = 1'b1;
    step();
    tick_m = 1'b0;
  endtask

  initial begin
    int lat;
    int v0;
    int lvl_m, lvl_h, hold_m, hold_h;

    // Reset state and a full hour of run-mode ticks.
    step();
    do_reset();
    wh_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      check("run_seq", val(), i % 60);
      if (i == 60) check("wrap_wh", int'(w_h), 1);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    check("run_wh_pulses", wh_seen, 1);

    // 09 -> 10 carries without an hour pulse.
    do_reset();
    repeat (9) do_tick();
    check("pre_carry", val(), 9);
    do_tick();
    check("carry_min_10", int'(min_10), 1);
    check("carry_min1", int'(min1), 0);
    check("carry_w_h", int'(w_h), 0);

    // A tick on the very edge that first samples set_mode high is ignored.
    set_mode = 1'b1;
    do_tick();
    check("mode_edge", val(), 10);
    set_mode = 1'b0;
    repeat (48) do_tick();
    check("at_58", val(), 58);

    // Set mode: three clean minute presses with tick_m noise, no hour pulse.
    set_mode = 1'b1;
    step();
    wh_seen = 0;
    for (int p = 0; p < 3; p++) begin
      btn_min = 1'b1;
      repeat (20) begin
        tick_m = 1'($urandom_range(0, 1));
        step();
      end
      tick_m  = 1'b0;
      btn_min = 1'b0;
      repeat (5) step();
      check("set_press", val(), (59 + p) % 60);
    end
    check("set_no_wh", wh_seen, 0);

    // Bouncing hour button, then stable high: one pulse, latency ~2+DB.
    wh_seen = 0;
    v0 = val();
    for (int i = 0; i < 30; i++) begin
      btn_hr = ((i / 3) % 2 == 0);
      step();
    end
    lat = -1;
    btn_hr = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (w_h && lat < 0) lat = j;
    end
    btn_hr = 1'b0;
    repeat (5) step();
    check("hr_pulses", wh_seen, 1);
    check("hr_lat_in_17_19", (lat >= 17 && lat <= 19) ? 1 : 0, 1);
    check("hr_min_hold", val(), v0);

    // Both buttons together: both actions.
    wh_seen = 0;
    v0 = val();
    btn_min = 1'b1;
    btn_hr  = 1'b1;
    repeat (20) step();
    btn_min = 1'b0;
    btn_hr  = 1'b0;
    repeat (3) step();
    check("both_wh", wh_seen, 1);
    check("both_min", val(), (v0 + 1) % 60);

    // Button held through reset is re-qualified from zero.
    btn_hr = 1'b1;
    do_reset();
    wh_seen = 0;
    repeat (25) step();
    btn_hr = 1'b0;
    step();
    check("rst_requal", wh_seen, 1);

    // Corrupted units digit in run mode -> 01.
    set_mode = 1'b0;
    do_reset();
    force dut.min1 = 4'd12;
    release dut.min1;
    bd_m10 = 0;
    bd_m1  = 12;
    bd_seq++;
    do_tick();
    check("bd_min1", val(), 1);

    // Corrupted tens digit -> 01.
    do_reset();
    force dut.min_10 = 4'd6;
    release dut.min_10;
    bd_m10 = 6;
    bd_m1  = 0;
    bd_seq++;
    do_tick();
    check("bd_min_10", val(), 1);

    // Reset asserted while w_h is high aborts the pulse immediately.
    do_reset();
    repeat (59) do_tick();
    do_tick();
    check("pre_rst_wh", int'(w_h), 1);
    do_reset();

    // Randomized mix of modes, ticks and button activity against the model.
    lvl_m = 0; lvl_h = 0; hold_m = 0; hold_h = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_m == 0) begin
        lvl_m  = int'($urandom_range(0, 1));
        hold_m = int'($urandom_range(1, 24));
      end
      if (hold_h == 0) begin
        lvl_h  = int'($urandom_range(0, 1));
        hold_h = int'($urandom_range(1, 24));
      end
      hold_m--;
      hold_h--;
      btn_min = (lvl_m != 0);
      btn_hr  = (lvl_h != 0);
      tick_m  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
